dl_edge_encoder: RTL and testbench
==================================

# dl_edge_encoder

Post-capture encoder for the clocked delay line. It accepts one captured tap vector per handshake and scans it one bit per clock. It reports the first 0/1 transition position (coarse edge), the total count of ones, and the number of additional transitions (bubbles). It sits downstream of the delay-line capture register and feeds its result fields to the UART reporting path in place of raw tap bytes.

## Interface
- p_dl_length, 64, number of delay-line taps in a capture; power of two, ≥ 4.
- p_dl_width, $clog2(p_dl_length), derived; not overridden.

- i_clk  input  1  sole clock; all state changes on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_cap_valid  input  1  capture vector presented.
- o_cap_ready  output  1  block idle and able to accept a capture.
- i_cap_data  input  p_dl_length  tap vector; bit 0 is the most recently sampled tap.
- o_res_valid  output  1  result fields valid.
- i_res_ready  input  1  consumer accepts result.
- o_res_found  output  1  at least one transition present.
- o_res_edge  output  p_dl_width  index of first transition; 0 when none.
- o_res_ones  output  p_dl_width+1  number of set bits in the capture.
- o_res_bubbles  output  p_dl_width  transitions after the first.

## Operation
- Interface decision: one clock (i_clk); reset i_rst is synchronous and active-high.
- States: IDLE, SCAN, DONE.
- IDLE
  - o_cap_ready = 1, gated low while i_rst = 1.
  - On i_cap_valid & o_cap_ready:
    - latch i_cap_data into the shadow register;
    - clear found, edge, ones and bubbles;
    - set idx = 0;
    - go to SCAN.
- SCAN
  - Each cycle, process bit idx of the shadow register:
    - ones += bit[idx].
    - If idx ≥ 1 and bit[idx] ≠ bit[idx-1], then: if found = 0, set found = 1 and edge = idx; otherwise bubbles += 1.
  - On idx = p_dl_length-1: process the bit, then go to DONE. Otherwise idx += 1.
- DONE
  - o_res_valid = 1. All result fields are held constant.
  - On i_res_ready, go to IDLE.
- Arithmetic:
  - ones maximum is p_dl_length, so it needs p_dl_width+1 bits.
  - bubbles maximum is p_dl_length-2, so it fits in p_dl_width bits.
  - No saturation logic is needed; no counter can wrap.
- Result fields are undefined-free: they are driven from the registered accumulators in every state. Consumers qualify them with o_res_valid only.
- i_cap_data is sampled only on the accepting edge. Later changes to i_cap_data do not affect the scan in progress.
- i_cap_valid while not in IDLE is ignored. The producer must hold it until accepted.

## Timing
- Reset values, applied on an edge with i_rst = 1:
  - state = IDLE, idx = 0;
  - o_res_valid = 0, o_res_found = 0, o_res_edge = 0, o_res_ones = 0, o_res_bubbles = 0;
  - o_cap_ready = 0 while i_rst is high, and 1 in the first cycle after i_rst falls.
- Latency: o_res_valid rises exactly p_dl_length edges after the accepting edge (64 for the default).
- Handshake: a result is consumed on the edge where o_res_valid & i_res_ready are both high. o_cap_ready is high in the following cycle.
- Minimum capture-to-capture period is p_dl_length+2 cycles.
- If i_res_ready is already high when DONE is entered, the result is valid for exactly one cycle.
- Reset mid-SCAN or in DONE: the scan is abandoned and no result is produced. The block behaves as freshly reset.
- In IDLE or SCAN, o_res_valid is never asserted.

## Test plan
- Reset, then capture 0x0000_0000_0000_0000 → after 64 edges: o_res_valid = 1, found = 0, edge = 0, ones = 0, bubbles = 0. Capture 0xFFFF_FFFF_FFFF_FFFF → found = 0, edge = 0, ones = 64, bubbles = 0.
- Capture 0x0000_0000_0000_00FF → found = 1, edge = 8, ones = 8, bubbles = 0. Capture 0x0000_0000_0000_0F0F → edge = 4, ones = 8, bubbles = 2.
- Capture 0xAAAA_AAAA_AAAA_AAAA → found = 1, edge = 1, ones = 32, bubbles = 62. Capture 0x8000_0000_0000_0000 → edge = 63, ones = 1, bubbles = 0.
- Backpressure check:
  - Hold i_res_ready = 0 for 10 cycles after o_res_valid rises → all result fields stable and o_cap_ready = 0 throughout.
  - Meanwhile assert i_cap_valid with different data → it is not accepted.
  - Release i_res_ready → o_cap_ready = 1 on the next cycle, and the pending capture is accepted.
- Change i_cap_data every cycle during SCAN → the result matches the vector present on the accepting edge.
- Assert i_rst for 1 cycle at idx = 20 → o_res_valid stays 0, and o_cap_ready = 1 on the cycle after release. The next capture of 0x00FF produces edge = 8 with no residue from the aborted scan.

Source files
------------

// File: rtl/dl_edge_encoder.sv
// Delay-line capture encoder: scans one latched tap vector a bit per clock and
// reports the first 0/1 transition, the count of ones and any extra transitions.
module dl_edge_encoder #(
    parameter int p_dl_length = 64,
    parameter int p_dl_width  = $clog2(p_dl_length)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cap_valid,
    output logic                   o_cap_ready,
    input  logic [p_dl_length-1:0] i_cap_data,
    output logic                   o_res_valid,
    input  logic                   i_res_ready,
    output logic                   o_res_found,
    output logic [p_dl_width-1:0]  o_res_edge,
    output logic [p_dl_width:0]    o_res_ones,
    output logic [p_dl_width-1:0]  o_res_bubbles
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    localparam logic [p_dl_width-1:0] idx_last = p_dl_width'(p_dl_length - 1);

    state_t                   state_reg,   state_next;
    logic [p_dl_length-1:0]   shadow_reg,  shadow_next;
    logic [p_dl_width-1:0]    idx_reg,     idx_next;
    logic                     found_reg,   found_next;
    logic [p_dl_width-1:0]    edge_reg,    edge_next;
    logic [p_dl_width:0]      ones_reg,    ones_next;
    logic [p_dl_width-1:0]    bubbles_reg, bubbles_next;

    // Per-tap transition flags against the previous tap; tap 0 has no predecessor.
    logic [p_dl_length-1:0]   trans_vec;
    logic                     cur_bit;
    logic                     cur_trans;

    assign trans_vec[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < p_dl_length; gi++) begin : g_trans
            assign trans_vec[gi] = shadow_reg[gi] ^ shadow_reg[gi-1];
        end
    endgenerate

    assign cur_bit   = shadow_reg[idx_reg];
    assign cur_trans = trans_vec[idx_reg];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            shadow_reg  <= '0;
            idx_reg     <= '0;
            found_reg   <= 1'b0;
            edge_reg    <= '0;
            ones_reg    <= '0;
            bubbles_reg <= '0;
        end else begin
            state_reg   <= state_next;
            shadow_reg  <= shadow_next;
            idx_reg     <= idx_next;
            found_reg   <= found_next;
            edge_reg    <= edge_next;
            ones_reg    <= ones_next;
            bubbles_reg <= bubbles_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shadow_next  = shadow_reg;
        idx_next     = idx_reg;
        found_next   = found_reg;
        edge_next    = edge_reg;
        ones_next    = ones_reg;
        bubbles_next = bubbles_reg;
        o_cap_ready  = 1'b0;
        o_res_valid  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                o_cap_ready = ~i_rst;
                if (i_cap_valid && !i_rst) begin
                    shadow_next  = i_cap_data;
                    found_next   = 1'b0;
                    edge_next    = '0;
                    ones_next    = '0;
                    bubbles_next = '0;
                    idx_next     = '0;
                    state_next   = ST_SCAN;
                end
            end

            ST_SCAN: begin
                ones_next = ones_reg + (p_dl_width + 1)'(cur_bit);
                if (cur_trans) begin
                    if (!found_reg) begin
                        found_next = 1'b1;
                        edge_next  = idx_reg;
                    end else begin
                        bubbles_next = bubbles_reg + p_dl_width'(1);
                    end
                end
                if (idx_reg == idx_last) begin
                    state_next = ST_DONE;
                end else begin
                    idx_next = idx_reg + p_dl_width'(1);
                end
            end

            ST_DONE: begin
                o_res_valid = 1'b1;
                if (i_res_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_res_found   = found_reg;
    assign o_res_edge    = edge_reg;
    assign o_res_ones    = ones_reg;
    assign o_res_bubbles = bubbles_reg;

endmodule

// File: tb/tb_dl_edge_encoder.sv
// Bench for dl_edge_encoder: a transaction-level model predicts handshake timing
// and result fields every cycle; directed captures are also checked against literals.
module tb_dl_edge_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cap_valid = 1'b0;
    logic        cap_ready;
    logic [63:0] cap_data = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        res_found;
    logic [5:0]  res_edge;
    logic [6:0]  res_ones;
    logic [5:0]  res_bubbles;

    int vectors = 0;
    int miscompares = 0;

    dl_edge_encoder dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cap_valid   (cap_valid),
        .o_cap_ready   (cap_ready),
        .i_cap_data    (cap_data),
        .o_res_valid   (res_valid),
        .i_res_ready   (res_ready),
        .o_res_found   (res_found),
        .o_res_edge    (res_edge),
        .o_res_ones    (res_ones),
        .o_res_bubbles (res_bubbles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: scan the vector as a list of taps and count transitions directly.
    task automatic ref_result(input logic [63:0] v, output logic f, output int e,
                              output int o, output int b);
        int trans;
        f = 1'b0; e = 0; o = 0; trans = 0;
        for (int i = 0; i < 64; i++) begin
            o += int'(v[i]);
            if (i > 0 && v[i] != v[i-1]) begin
                if (trans == 0) begin
                    f = 1'b1;
                    e = i;
                end
                trans++;
            end
        end
        b = (trans > 0) ? trans - 1 : 0;
    endtask

    // Phase model: 0 = idle, 1 = scanning (countdown of taps), 2 = result held.
    int          m_phase = 0;
    int          m_left  = 0;
    logic [63:0] m_vec   = '0;
    logic        m_live  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_live  <= 1'b1;
        end else begin
            case (m_phase)
                0: if (cap_valid) begin
                    m_vec   <= cap_data;
                    m_left  <= 64;
                    m_phase <= 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_phase <= 2;
                end
                default: if (res_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic f;
        int   e, o, b;
        if (m_live) begin
            check("cap_ready", longint'(cap_ready), longint'(m_phase == 0 && !rst));
            check("res_valid", longint'(res_valid), longint'(m_phase == 2));
            if (m_phase == 2) begin
                ref_result(m_vec, f, e, o, b);
                check("model_found",   longint'(res_found),   longint'(f));
                check("model_edge",    longint'(res_edge),    longint'(e));
                check("model_ones",    longint'(res_ones),    longint'(o));
                check("model_bubbles", longint'(res_bubbles), longint'(b));
            end
        end
    end

    logic [63:0] tv [6];
    int          tf [6];
    int          te [6];
    int          to [6];
    int          tb [6];

    task automatic do_cap(input logic [63:0] d);
        int n;
        cap_valid = 1'b1;
        cap_data  = d;
        for (n = 0; n < 300; n++) begin
            if (cap_ready) break;
            @(negedge clk);
        end
        if (n == 300) begin
            miscompares++;
            $display("FAIL accept_timeout: got no cap_ready expected cap_ready within 300 cycles");
        end
        @(negedge clk);
        cap_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        for (n = 0; n < 200; n++) begin
            if (res_valid) break;
            @(negedge clk);
        end
        if (n == 200) begin
            miscompares++;
            $display("FAIL result_timeout: got no res_valid expected res_valid within 200 cycles");
        end
    endtask

    task automatic check_lit(input int k);
        $display("result for %h: found=%0d edge=%0d ones=%0d bubbles=%0d",
                 tv[k], res_found, res_edge, res_ones, res_bubbles);
        check("lit_found",   longint'(res_found),   longint'(tf[k]));
        check("lit_edge",    longint'(res_edge),    longint'(te[k]));
        check("lit_ones",    longint'(res_ones),    longint'(to[k]));
        check("lit_bubbles", longint'(res_bubbles), longint'(tb[k]));
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        logic f;
        int   e, o, b;

        tv[0] = 64'h0000_0000_0000_0000; tf[0] = 0; te[0] = 0;  to[0] = 0;  tb[0] = 0;
        tv[1] = 64'hFFFF_FFFF_FFFF_FFFF; tf[1] = 0; te[1] = 0;  to[1] = 64; tb[1] = 0;
        tv[2] = 64'h0000_0000_0000_00FF; tf[2] = 1; te[2] = 8;  to[2] = 8;  tb[2] = 0;
        tv[3] = 64'h0000_0000_0000_0F0F; tf[3] = 1; te[3] = 4;  to[3] = 8;  tb[3] = 2;
        tv[4] = 64'hAAAA_AAAA_AAAA_AAAA; tf[4] = 1; te[4] = 1;  to[4] = 32; tb[4] = 62;
        tv[5] = 64'h8000_0000_0000_0000; tf[5] = 1; te[5] = 63; to[5] = 1;  tb[5] = 0;

        // Pin the reference model itself against the hand-computed table.
        for (int k = 0; k < 6; k++) begin
            ref_result(tv[k], f, e, o, b);
            check("ref_found",   longint'(f), longint'(tf[k]));
            check("ref_edge",    longint'(e), longint'(te[k]));
            check("ref_ones",    longint'(o), longint'(to[k]));
            check("ref_bubbles", longint'(b), longint'(tb[k]));
        end

        repeat (3) @(negedge clk);
        check("rst_cap_ready", longint'(cap_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cap_ready", longint'(cap_ready), 1);
        check("post_rst_valid",     longint'(res_valid), 0);
        check("post_rst_found",     longint'(res_found), 0);
        check("post_rst_edge",      longint'(res_edge), 0);
        check("post_rst_ones",      longint'(res_ones), 0);
        check("post_rst_bubbles",   longint'(res_bubbles), 0);

        for (int k = 0; k < 5; k++) begin
            do_cap(tv[k]);
            wait_valid();
            check_lit(k);
            consume();
        end

        // Consumer already ready when the result appears: one-cycle valid.
        res_ready = 1'b1;
        do_cap(tv[5]);
        wait_valid();
        check_lit(5);
        consume();

        // Backpressure with a competing capture pending.
        do_cap(tv[2]);
        wait_valid();
        check_lit(2);
        cap_valid = 1'b1;
        cap_data  = tv[3];
        repeat (10) begin
            @(negedge clk);
            check("bp_cap_ready", longint'(cap_ready), 0);
            check("bp_edge",      longint'(res_edge), 8);
        end
        consume();
        check("bp_release_ready", longint'(cap_ready), 1);
        @(negedge clk);
        cap_valid = 1'b0;
        wait_valid();
        check_lit(3);
        consume();

        // Input data churns during the scan; result must reflect the accepted vector.
        do_cap(tv[5]);
        repeat (60) begin
            cap_data = {$urandom(), $urandom()};
            @(negedge clk);
        end
        wait_valid();
        check_lit(5);
        consume();

        // Reset in the middle of a scan (idx = 20).
        do_cap(tv[3]);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", longint'(res_valid), 0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_cap_ready", longint'(cap_ready), 1);
        do_cap(tv[2]);
        wait_valid();
        check_lit(2);
        consume();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
